// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle decode/execute controller driving the ALU, register file and PSR
module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [3:0]       rf_raddr_src,
    output logic [3:0]       rf_raddr_dst,
    output logic             alu_src_imm,
    output logic [WIDTH-1:0] imm_ext,
    output logic [2:0]       alucont,
    input  logic [4:0]       alu_psr,
    output logic             rf_we,
    output logic [3:0]       rf_waddr,
    output logic [4:0]       psr_q,
    output logic             done,
    output logic             illegal
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_WB     = 2'd3;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_CMP = 3'b101;
    localparam logic [2:0] ALU_MOV = 3'b110;

    // PSR bit positions: [0]C [1]F [2]L [3]Z [4]N
    localparam logic [4:0] MASK_CF  = 5'b00011;
    localparam logic [4:0] MASK_CFL = 5'b00111;
    localparam logic [4:0] MASK_ZN  = 5'b11000;

    logic [1:0]       state_q, state_d;
    logic [15:0]      ir_q, ir_d;
    logic [2:0]       alucont_q, alucont_d;
    logic             src_imm_q, src_imm_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic             we_q, we_d;
    logic             ill_q, ill_d;
    logic [4:0]       mask_q, mask_d;
    logic [4:0]       psr_d;

    logic [3:0]       ir_op;
    logic [3:0]       ir_opext;
    logic [7:0]       ir_imm8;
    logic [3:0]       dec_key;
    logic             dec_is_imm;
    logic [2:0]       dec_alucont;
    logic             dec_we;
    logic             dec_ill;
    logic             dec_sext;
    logic [4:0]       dec_mask;
    logic [WIDTH-1:0] dec_imm;
    logic             accept;
    logic             wb_fire;

    assign ir_op    = ir_q[15:12];
    assign ir_opext = ir_q[7:4];
    assign ir_imm8  = ir_q[7:0];

    // Immediate forms reuse the register-form opext code as their primary opcode.
    assign dec_is_imm = (ir_op != 4'b0000);
    assign dec_key    = dec_is_imm ? ir_op : ir_opext;

    always_comb begin
        dec_alucont = ALU_MOV;
        dec_we      = 1'b0;
        dec_ill     = 1'b0;
        dec_sext    = 1'b0;
        dec_mask    = 5'b00000;
        case (dec_key)
            4'b0101: begin
                dec_alucont = ALU_ADD;
                dec_we      = 1'b1;
                dec_sext    = 1'b1;
                dec_mask    = MASK_CF;
            end
            4'b1001: begin
                dec_alucont = ALU_SUB;
                dec_we      = 1'b1;
                dec_sext    = 1'b1;
                dec_mask    = MASK_CFL;
            end
            4'b0001: begin
                dec_alucont = ALU_AND;
                dec_we      = 1'b1;
            end
            4'b0011: begin
                dec_alucont = ALU_XOR;
                dec_we      = 1'b1;
            end
            4'b0010: begin
                dec_alucont = ALU_OR;
                dec_we      = 1'b1;
            end
            4'b1011: begin
                dec_alucont = ALU_CMP;
                dec_sext    = 1'b1;
                dec_mask    = MASK_ZN;
            end
            4'b1101: begin
                dec_alucont = ALU_MOV;
                dec_we      = 1'b1;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
    end

    always_comb begin
        dec_imm = '0;
        if (dec_is_imm && !dec_ill) begin
            if (dec_sext) begin
                dec_imm = {{(WIDTH-8){ir_imm8[7]}}, ir_imm8};
            end else begin
                dec_imm = {{(WIDTH-8){1'b0}}, ir_imm8};
            end
        end
    end

    assign accept  = (state_q == S_IDLE) && instr_valid && !reset;
    assign wb_fire = (state_q == S_WB) && !reset;

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        alucont_d = alucont_q;
        src_imm_d = src_imm_q;
        imm_d     = imm_q;
        we_d      = we_q;
        ill_d     = ill_q;
        mask_d    = mask_q;
        psr_d     = psr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alucont_d = dec_alucont;
                src_imm_d = dec_is_imm && !dec_ill;
                imm_d     = dec_imm;
                we_d      = dec_we && !dec_ill;
                ill_d     = dec_ill;
                mask_d    = dec_ill ? 5'b00000 : dec_mask;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                psr_d   = (psr_q & ~mask_q) | (alu_psr & mask_q);
                state_d = S_WB;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            alucont_q <= ALU_ADD;
            src_imm_q <= 1'b0;
            imm_q     <= '0;
            we_q      <= 1'b0;
            ill_q     <= 1'b0;
            mask_q    <= '0;
            psr_q     <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            alucont_q <= alucont_d;
            src_imm_q <= src_imm_d;
            imm_q     <= imm_d;
            we_q      <= we_d;
            ill_q     <= ill_d;
            mask_q    <= mask_d;
            psr_q     <= psr_d;
        end
    end

    // Strobes are gated by reset so an instruction caught in WB by reset never retires.
    assign instr_ready  = (state_q == S_IDLE) && !reset;
    assign rf_raddr_src = ir_q[3:0];
    assign rf_raddr_dst = ir_q[11:8];
    assign rf_waddr     = ir_q[11:8];
    assign alucont      = alucont_q;
    assign alu_src_imm  = src_imm_q;
    assign imm_ext      = imm_q;
    assign rf_we        = wb_fire && we_q;
    assign done         = wb_fire;
    assign illegal      = wb_fire && ill_q;

endmodule
